window_gen_3x3: RTL and testbench

- Streams a raster-ordered image one pixel per handshake and produces every fully-populated 3×3 neighbourhood as a registered window.
- Generalises the fixed 8-bit, 540-column line buffer:
  - parametrised pixel width and maximum line length;
  - run-time frame width and height;
  - valid/ready backpressure on both sides;
  - rolling line storage, so rows are never re-fetched;
  - frame-level start/done control.
- Sits between the memory controller read stream and the 3×3 filter core.

---
 rtl/window_gen_pkg.sv | 29 ++
 rtl/window_gen_3x3_if.sv | 31 +++
 rtl/window_gen_3x3_line_buffer.sv | 30 +++
 rtl/window_gen_3x3.sv | 193 +++++++++++++++++++
 tb/tb_window_gen_3x3.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/window_gen_pkg.sv
// Shared definitions for the 3x3 window generator.
//   state_t      : frame-control FSM states (IDLE, RUN, FLUSH)
//   WIN_K        : window edge length
//   MIN_DIM      : smallest legal frame width/height
//   WIN_N        : number of taps in a window
//   WIN_*        : row-major tap indices, WIN_TL = top-left ... WIN_BR = bottom-right
package window_gen_pkg;

    localparam int WIN_K   = 3;
    localparam int MIN_DIM = 3;
    localparam int WIN_N   = WIN_K * WIN_K;

    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out stream bundle for window_gen_3x3.
//   in_data_i, in_valid_i, in_ready_o : pixel stream into the generator
//   win_o, win_valid_o, win_ready_i   : 3x3 window stream out of the generator
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid must keep its data stable until that
// edge; valid never waits on ready, ready may depend on valid.
// Modports: master = the side feeding pixels and consuming windows,
//           slave  = the window generator itself.
interface window_gen_3x3_if #(
    parameter int DATA_W = 8
);
    import window_gen_pkg::*;

    logic [DATA_W-1:0]             in_data_i;
    logic                          in_valid_i;
    logic                          in_ready_o;
    logic [WIN_N-1:0][DATA_W-1:0]  win_o;
    logic                          win_valid_o;
    logic                          win_ready_i;

    modport master (
        output in_data_i, in_valid_i, win_ready_i,
        input  in_ready_o, win_o, win_valid_o
    );

    modport slave (
        input  in_data_i, in_valid_i, win_ready_i,
        output in_ready_o, win_o, win_valid_o
    );

endinterface

// File: rtl/window_gen_3x3_line_buffer.sv
// One line of pixel storage for the window generator.
//   clk   : clock
//   we    : write enable
//   addr  : column address, shared by the read and write ports
//   wdata : pixel written at addr on the rising edge
//   rdata : combinational read of addr (old contents during a write cycle)
// Contents are deliberately not reset; the generator never exposes a
// location before it has been written in the current frame.
module line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 540
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/window_gen_3x3.sv
// 3x3 neighbourhood generator for a raster-ordered pixel stream.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start_i          : one-cycle pulse, latches cfg_width_i/cfg_height_i
//   cfg_width_i      : frame width W  (legal 3..MAX_COL)
//   cfg_height_i     : frame height H (legal 3..MAX_ROW)
//   busy_o           : frame in progress
//   cfg_err_o        : sticky illegal-configuration flag
//   frame_done_o     : one-cycle pulse after the last window handshake
//   state_o          : FSM state, for observation
//   bus              : pixel input stream and window output stream
// Two line buffers hold the previous two rows (lbA = two rows up, lbB = one
// row up). Each accepted pixel reads its column from both, rolls the column
// up one row, and shifts {top, mid, pixel} into the right of the window.
module window_gen_3x3
    import window_gen_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int MAX_COL = 540,
    parameter int MAX_ROW = 540
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic [$clog2(MAX_COL+1)-1:0] cfg_width_i,
    input  logic [$clog2(MAX_ROW+1)-1:0] cfg_height_i,
    output logic                         busy_o,
    output logic                         cfg_err_o,
    output logic                         frame_done_o,
    output state_t                       state_o,
    window_gen_3x3_if.slave              bus
);

    localparam int WW = $clog2(MAX_COL + 1);
    localparam int HW = $clog2(MAX_ROW + 1);
    localparam int CW = $clog2(MAX_COL);
    localparam int RW = $clog2(MAX_ROW);

    localparam logic [WW-1:0] W_MIN    = WW'(MIN_DIM);
    localparam logic [WW-1:0] W_MAX    = WW'(MAX_COL);
    localparam logic [HW-1:0] H_MIN    = HW'(MIN_DIM);
    localparam logic [HW-1:0] H_MAX    = HW'(MAX_ROW);
    localparam logic [CW-1:0] COL_EDGE = CW'(WIN_K - 1);
    localparam logic [RW-1:0] ROW_EDGE = RW'(WIN_K - 1);

    state_t                        state_q, state_d;
    logic [CW-1:0]                 col_q, w_last_q;
    logic [RW-1:0]                 row_q, h_last_q;
    logic [WIN_N-1:0][DATA_W-1:0]  win_q;
    logic                          win_valid_q;
    logic                          cfg_err_q;
    logic                          frame_done_q;

    logic                          cfg_ok;
    logic                          in_ready;
    logic                          accept;
    logic                          win_hs;
    logic                          col_wrap;
    logic                          last_px;
    logic                          win_fire;
    logic [DATA_W-1:0]             lb_top;
    logic [DATA_W-1:0]             lb_mid;

    assign cfg_ok   = (cfg_width_i  >= W_MIN) && (cfg_width_i  <= W_MAX) &&
                      (cfg_height_i >= H_MIN) && (cfg_height_i <= H_MAX);
    assign col_wrap = (col_q == w_last_q);
    assign last_px  = col_wrap && (row_q == h_last_q);
    // A window is complete once two full rows and two columns sit behind p.
    assign win_fire = (row_q >= ROW_EDGE) && (col_q >= COL_EDGE);
    assign win_hs   = win_valid_q && bus.win_ready_i;
    assign accept   = bus.in_valid_i && in_ready;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && cfg_ok) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // The window register is overwritten by every accepted pixel,
                // so a pixel may only enter when the current window drains.
                in_ready = !win_valid_q || bus.win_ready_i;
                if (bus.in_valid_i && in_ready && last_px) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (win_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- line buffers ----------------
    line_buffer #(.DATA_W(DATA_W), .DEPTH(MAX_COL)) u_lb_a (
        .clk   (clk),
        .we    (accept),
        .addr  (col_q),
        .wdata (lb_mid),
        .rdata (lb_top)
    );

    line_buffer #(.DATA_W(DATA_W), .DEPTH(MAX_COL)) u_lb_b (
        .clk   (clk),
        .we    (accept),
        .addr  (col_q),
        .wdata (bus.in_data_i),
        .rdata (lb_mid)
    );

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            w_last_q     <= '0;
            h_last_q     <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            cfg_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (cfg_ok) begin
                            cfg_err_q <= 1'b0;
                            w_last_q  <= CW'(cfg_width_i - WW'(1));
                            h_last_q  <= RW'(cfg_height_i - HW'(1));
                            col_q     <= '0;
                            row_q     <= '0;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        for (int r = 0; r < WIN_K; r++) begin
                            win_q[r*WIN_K + 0] <= win_q[r*WIN_K + 1];
                            win_q[r*WIN_K + 1] <= win_q[r*WIN_K + 2];
                        end
                        win_q[WIN_TR] <= lb_top;
                        win_q[WIN_MR] <= lb_mid;
                        win_q[WIN_BR] <= bus.in_data_i;
                        win_valid_q   <= win_fire;
                        if (last_px) begin
                            col_q <= '0;
                            row_q <= '0;
                        end else if (col_wrap) begin
                            col_q <= '0;
                            row_q <= row_q + RW'(1);
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end else if (win_hs) begin
                        win_valid_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (win_hs) begin
                        win_valid_q  <= 1'b0;
                        frame_done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.win_o       = win_q;
    assign bus.win_valid_o = win_valid_q;
    assign busy_o          = (state_q != IDLE);
    assign cfg_err_o       = cfg_err_q;
    assign frame_done_o    = frame_done_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed + randomized bench for window_gen_3x3. Expected windows come from
// a frame model: every interior pixel (r,c) yields the 3x3 block of the
// stored frame centred on it, in raster order.
module tb_window_gen_3x3;
    import window_gen_pkg::*;

    localparam int DW   = 10;
    localparam int MAXC = 540;
    localparam int MAXR = 540;

    logic                          clk;
    logic                          rst_n;
    logic                          start_i;
    logic [$clog2(MAXC+1)-1:0]     cfg_width_i;
    logic [$clog2(MAXR+1)-1:0]     cfg_height_i;
    logic                          busy_o;
    logic                          cfg_err_o;
    logic                          frame_done_o;
    state_t                        state_o;

    window_gen_3x3_if #(.DATA_W(DW)) bus ();

    window_gen_3x3 #(.DATA_W(DW), .MAX_COL(MAXC), .MAX_ROW(MAXR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .cfg_width_i  (cfg_width_i),
        .cfg_height_i (cfg_height_i),
        .busy_o       (busy_o),
        .cfg_err_o    (cfg_err_o),
        .frame_done_o (frame_done_o),
        .state_o      (state_o),
        .bus          (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ready_pattern(input int rmode, input int cyc);
        case (rmode)
            0:       return 1'b1;
            1:       return (cyc % 4 == 0) || (cyc % 4 == 3);   // 1-0-0-1
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // mode 0: ramp i, 1: 1023-i, 2: random. rmode: window-ready pattern.
    // vmode 0: pixels offered every cycle, 1: random gaps.
    task automatic run_frame(input int w, input int h, input int mode,
                             input int rmode, input int vmode, input string name);
        logic [DW-1:0]   pix[$];
        logic [9*DW-1:0] exp_q[$];
        logic [9*DW-1:0] e;
        logic [9*DW-1:0] held;
        int npix, n_exp, idx, got, done_cnt, cyc, done_cyc, first_cyc, budget;
        logic stalled;

        npix = w * h;
        for (int i = 0; i < npix; i++) begin
            case (mode)
                0:       pix.push_back(DW'(i));
                1:       pix.push_back(DW'(1023 - i));
                default: pix.push_back(DW'($urandom_range(0, 1023)));
            endcase
        end
        for (int r = 1; r <= h - 2; r++) begin
            for (int c = 1; c <= w - 2; c++) begin
                for (int k = 0; k < 9; k++) begin
                    e[k*DW +: DW] = pix[(r - 1 + k / 3) * w + (c - 1 + k % 3)];
                end
                exp_q.push_back(e);
            end
        end
        n_exp = exp_q.size();

        @(negedge clk);
        cfg_width_i     = ($clog2(MAXC+1))'(w);
        cfg_height_i    = ($clog2(MAXR+1))'(h);
        start_i         = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.win_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check({name, "_busy_after_start"}, busy_o, 1);
        check({name, "_cfg_err_cleared"}, cfg_err_o, 0);
        check({name, "_in_ready_after_start"}, bus.in_ready_o, 1);

        idx = 0; got = 0; done_cnt = 0; cyc = 0; done_cyc = -1; first_cyc = -1;
        stalled = 1'b0; held = '0;
        budget = npix * 8 + 100;
        while (cyc < budget) begin
            if (stalled) begin
                check({name, "_stall_hold_win"}, bus.win_o, held);
                check({name, "_stall_hold_valid"}, bus.win_valid_o, 1);
            end
            if (frame_done_o) begin
                done_cnt++;
                done_cyc = cyc;
                check({name, "_busy_at_done"}, busy_o, 0);
                break;
            end
            if (bus.win_valid_o && first_cyc < 0) first_cyc = cyc;
            if (idx == npix) check({name, "_flush_in_ready"}, bus.in_ready_o, 0);

            bus.win_ready_i = ready_pattern(rmode, cyc);
            bus.in_valid_i  = (idx < npix) && (vmode == 0 || $urandom_range(0, 3) != 0);
            bus.in_data_i   = (idx < npix) ? pix[idx] : DW'($urandom_range(0, 1023));
            if (!bus.in_valid_i) bus.in_data_i = DW'($urandom_range(0, 1023));
            #1;
            if (bus.win_valid_o && !bus.win_ready_i)
                check({name, "_stall_in_ready"}, bus.in_ready_o, 0);
            if (bus.win_valid_o && bus.win_ready_i) begin
                if (exp_q.size() == 0) begin
                    check({name, "_unexpected_window"}, bus.win_valid_o, 0);
                end else begin
                    check({name, "_window"}, bus.win_o, exp_q.pop_front());
                end
                got++;
            end
            stalled = bus.win_valid_o && !bus.win_ready_i;
            held    = bus.win_o;
            if (bus.in_valid_i && bus.in_ready_o) idx++;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid_i = 1'b0;

        check({name, "_frame_done_count"}, done_cnt, 1);
        check({name, "_window_count"}, got, n_exp);
        check({name, "_pixels_taken"}, idx, npix);
        if (rmode == 0 && vmode == 0) begin
            check({name, "_frame_cycles"}, done_cyc, npix + 1);
            check({name, "_first_window_latency"}, first_cyc, 2 * w + 3);
        end
        @(negedge clk);
        check({name, "_done_pulse_single"}, frame_done_o, 0);
    endtask

    initial begin
        int acc;
        int cyc;

        rst_n           = 1'b0;
        start_i         = 1'b0;
        cfg_width_i     = '0;
        cfg_height_i    = '0;
        bus.in_data_i   = '0;
        bus.in_valid_i  = 1'b0;
        bus.win_ready_i = 1'b0;

        // reset values
        repeat (2) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_cfg_err", cfg_err_o, 0);
        check("rst_frame_done", frame_done_o, 0);
        check("rst_win_valid", bus.win_valid_o, 0);
        check("rst_in_ready", bus.in_ready_o, 0);
        check("rst_win", bus.win_o, 0);
        check("rst_state", state_o, IDLE);
        rst_n = 1'b1;

        // ramp frame, full rate
        run_frame(5, 4, 0, 0, 0, "ramp");

        // backpressure 1-0-0-1
        run_frame(5, 4, 0, 1, 0, "bp");

        // illegal configurations
        @(negedge clk);
        cfg_width_i = 2; cfg_height_i = 4; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("ill_w_cfg_err", cfg_err_o, 1);
        check("ill_w_busy", busy_o, 0);
        cfg_width_i = 5; cfg_height_i = ($clog2(MAXR+1))'(MAXR + 1); start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("ill_h_cfg_err", cfg_err_o, 1);
        check("ill_h_busy", busy_o, 0);
        @(negedge clk);
        check("ill_sticky", cfg_err_o, 1);
        run_frame(5, 4, 0, 0, 0, "after_illegal");

        // reset in the middle of a frame
        @(negedge clk);
        cfg_width_i = 5; cfg_height_i = 4; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        bus.win_ready_i = 1'b1;
        bus.in_valid_i  = 1'b1;
        acc = 0; cyc = 0;
        while (acc < 7 && cyc < 50) begin
            bus.in_data_i = DW'(acc + 1);
            #1;
            if (bus.in_ready_o) acc++;
            @(negedge clk);
            cyc++;
        end
        check("midrst_pixels_taken", acc, 7);
        rst_n = 1'b0;
        bus.in_valid_i = 1'b0;
        #1;
        check("midrst_busy", busy_o, 0);
        check("midrst_win_valid", bus.win_valid_o, 0);
        check("midrst_in_ready", bus.in_ready_o, 0);
        check("midrst_win", bus.win_o, 0);
        check("midrst_frame_done", frame_done_o, 0);
        check("midrst_state", state_o, IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(5, 4, 0, 0, 0, "post_rst");

        // back-to-back frames with descending values
        run_frame(4, 3, 1, 0, 0, "b2b_a");
        run_frame(6, 5, 1, 0, 0, "b2b_b");

        // randomized frames, sizes, gaps and backpressure
        for (int t = 0; t < 4; t++) begin
            run_frame($urandom_range(3, 12), $urandom_range(3, 8), 2, 2, 1, "rand");
        end

        // full width
        run_frame(MAXC, 3, 2, 0, 0, "full_w");
        run_frame(MAXC, 4, 0, 2, 1, "full_w_bp");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
